// File: rtl/phase_seq_pkg.sv
// Shared definitions for the instruction-phase sequencer and the datapath that
// consumes its phase numbering.
package phase_seq_pkg;

  localparam int DEFAULT_NUM_PHASES = 5;
  localparam int DEFAULT_PHASE_W    = 3;

  typedef logic [DEFAULT_PHASE_W-1:0] phase_idx_t;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    DRAINING = 2'd2,
    HALTED   = 2'd3
  } seq_state_t;

  // Phases advance only in these two states.
  function automatic logic is_active(input seq_state_t s);
    return (s == RUNNING) || (s == DRAINING);
  endfunction

endpackage

// File: rtl/phase_sequencer_button_edge_sync.sv
// Synchronizer plus rising-edge detector for an asynchronous front-panel button.
// Every flop resets to the "pressed" level so a button held through reset is not seen as an edge.
module button_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   prev_reg;
  logic                   rise_reg;

  assign sync_next[0] = button;

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
      rise_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer with run/stop/halt control.
// Optional single-step button enabled by defining PHASE_SEQ_SINGLE_STEP_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES  = DEFAULT_NUM_PHASES,
  parameter int PHASE_W     = DEFAULT_PHASE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  halt,
`ifdef PHASE_SEQ_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  running,
  output logic                  halted,
  output logic                  instr_done
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  seq_state_t              state_reg, state_next;
  logic [PHASE_W-1:0]      phase_reg, phase_next;
  logic                    halt_pending_reg, halt_pending_next;
  logic [NUM_PHASES-1:0]   phase_en_reg, phase_en_next;
  logic                    running_reg, running_next;
  logic                    halted_reg, halted_next;
  logic                    instr_done_reg, instr_done_next;
  logic [NUM_PHASES-1:0]   onehot_next;
  logic                    active_next;
  logic                    exec_rise;
  logic                    step_rise;
  logic                    end_of_instr;
  logic                    halt_seen;

  button_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_exec_sync (
    .clock  (clock),
    .reset  (reset),
    .button (exec),
    .rise   (exec_rise)
  );

`ifdef PHASE_SEQ_SINGLE_STEP_EN
  button_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_step_sync (
    .clock  (clock),
    .reset  (reset),
    .button (step),
    .rise   (step_rise)
  );
`else
  assign step_rise = 1'b0;
`endif

  assign end_of_instr = is_active(state_reg) && (phase_reg == LAST_PHASE);
  assign halt_seen    = halt_pending_reg || halt;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= STOPPED;
      phase_reg        <= '0;
      halt_pending_reg <= 1'b0;
      phase_en_reg     <= '0;
      running_reg      <= 1'b0;
      halted_reg       <= 1'b0;
      instr_done_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      halt_pending_reg <= halt_pending_next;
      phase_en_reg     <= phase_en_next;
      running_reg      <= running_next;
      halted_reg       <= halted_next;
      instr_done_reg   <= instr_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next        = state_reg;
    phase_next        = phase_reg;
    halt_pending_next = halt_pending_reg;

    case (state_reg)
      STOPPED: begin
        if (exec_rise) begin
          state_next = RUNNING;
          phase_next = '0;
        end else if (step_rise) begin
          state_next = DRAINING;
          phase_next = '0;
        end
      end

      RUNNING, DRAINING: begin
        if (halt) begin
          halt_pending_next = 1'b1;
        end
        if (end_of_instr) begin
          phase_next = '0;
          // A stop press landing on the last phase takes effect at this boundary.
          if (halt_seen) begin
            state_next = HALTED;
          end else if ((state_reg == DRAINING) || exec_rise) begin
            state_next = STOPPED;
          end
        end else begin
          phase_next = phase_reg + 1'b1;
          if ((state_reg == RUNNING) && exec_rise) begin
            state_next = DRAINING;
          end
        end
      end

      HALTED: begin
        if (exec_rise) begin
          state_next = RUNNING;
          phase_next = '0;
        end
      end

      default: begin
        state_next = STOPPED;
        phase_next = '0;
      end
    endcase

    if (state_next == HALTED) begin
      halt_pending_next = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_onehot
      assign onehot_next[gi] = (phase_next == PHASE_W'(gi));
    end
  endgenerate

  // Outputs are decoded from the next state so they line up with the registered phase.
  always_comb begin
    active_next     = is_active(state_next);
    phase_en_next   = '0;
    if (active_next) begin
      phase_en_next = onehot_next;
    end
    instr_done_next = active_next && (phase_next == LAST_PHASE);
    running_next    = active_next;
    halted_next     = (state_next == HALTED);
  end

  assign phase      = phase_reg;
  assign phase_en   = phase_en_reg;
  assign running    = running_reg;
  assign halted     = halted_reg;
  assign instr_done = instr_done_reg;

endmodule
